// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-set controller: FSM states,
// one-hot cursor codes and per-digit BCD limits.
package time_set_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int NUM_DIG = 6;
  localparam int DIG_W   = 4;

  localparam logic [NUM_DIG-1:0] CUR_SEC0 = 6'b000001;
  localparam logic [NUM_DIG-1:0] CUR_SEC1 = 6'b000010;
  localparam logic [NUM_DIG-1:0] CUR_MIN0 = 6'b000100;
  localparam logic [NUM_DIG-1:0] CUR_MIN1 = 6'b001000;
  localparam logic [NUM_DIG-1:0] CUR_HRS0 = 6'b010000;
  localparam logic [NUM_DIG-1:0] CUR_HRS1 = 6'b100000;

  localparam logic [DIG_W-1:0] LIM_9      = 4'd9;
  localparam logic [DIG_W-1:0] LIM_5      = 4'd5;
  localparam logic [DIG_W-1:0] LIM_2      = 4'd2;
  localparam logic [DIG_W-1:0] HRS0_CLAMP = 4'd3;

  // Index 0 = sec0 ... index 5 = hrs1
  localparam logic [NUM_DIG-1:0][DIG_W-1:0] DIG_LIM =
    {LIM_2, LIM_9, LIM_5, LIM_9, LIM_5, LIM_9};

  function automatic logic [NUM_DIG-1:0] onehot6(input logic [2:0] idx);
    return CUR_SEC0 << idx;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational single-digit step: increment/decrement with wrap in 0..lim.
// up wins if both are asserted; an out-of-range value steps down to lim.
module bcd_digit_step (
  input  logic [3:0] val,
  input  logic [3:0] lim,
  input  logic       up,
  input  logic       down,
  output logic [3:0] nxt
);

  always_comb begin
    nxt = val;
    if (up)
      nxt = (val >= lim) ? 4'd0 : val + 4'd1;
    else if (down)
      nxt = (val == 4'd0 || val > lim) ? lim : val - 4'd1;
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: snapshot live time, edit one BCD digit at a time, then
// sweep all six clamped digits back into the counter. Optional idle auto-commit
// is enabled by defining TIME_SET_TIMEOUT_EN.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int BLINK_DIV      = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] sec0,
  input  logic [3:0] sec1,
  input  logic [3:0] min0,
  input  logic [3:0] min1,
  input  logic [3:0] hrs0,
  input  logic [3:0] hrs1,
  output logic       set_en,
  output logic [5:0] cursor,
  output logic [3:0] n_sec0,
  output logic [3:0] n_sec1,
  output logic [3:0] n_min0,
  output logic [3:0] n_min1,
  output logic [3:0] n_hrs0,
  output logic [3:0] n_hrs1,
  output logic       blink
);

  localparam int BW = $clog2(BLINK_DIV + 1);

  state_e                           state, state_nxt;
  logic [2:0]                       sweep, sweep_nxt;
  logic [NUM_DIG-1:0][DIG_W-1:0]    dig, dig_nxt, dig_step, live;
  logic [NUM_DIG-1:0]               cur_nxt;
  logic                             set_en_nxt, blink_nxt;
  logic [BW-1:0]                    blink_cnt, blink_cnt_nxt;
  logic                             in_edit, any_btn, expire, go_commit;
  logic                             act_left, act_right, act_up, act_down;

  assign live    = {hrs1, hrs0, min1, min0, sec1, sec0};
  assign in_edit = (state == ST_EDIT);
  assign any_btn = btn_mode | btn_left | btn_right | btn_up | btn_down;

  // One action per cycle: mode > left > right > up > down
  assign act_left  = in_edit & ~btn_mode & btn_left;
  assign act_right = in_edit & ~btn_mode & ~btn_left & btn_right;
  assign act_up    = in_edit & ~btn_mode & ~btn_left & ~btn_right & btn_up;
  assign act_down  = in_edit & ~btn_mode & ~btn_left & ~btn_right & ~btn_up & btn_down;

`ifdef TIME_SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  assign expire = in_edit & ~any_btn & (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_cnt <= '0;
    else if (in_edit && state_nxt == ST_EDIT && !any_btn)
      idle_cnt <= idle_cnt + 1'b1;
    else
      idle_cnt <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = 1'b0;
`endif

  assign go_commit = in_edit & (btn_mode | expire);

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    bcd_digit_step u_step (
      .val  (dig[i]),
      .lim  (DIG_LIM[i]),
      .up   (act_up & cursor[i]),
      .down (act_down & cursor[i]),
      .nxt  (dig_step[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (btn_mode)      state_nxt = ST_EDIT;
      ST_EDIT:   if (go_commit)     state_nxt = ST_COMMIT;
      ST_COMMIT: if (sweep == 3'd5) state_nxt = ST_RUN;
      default:                      state_nxt = ST_RUN;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    sweep_nxt     = (state == ST_COMMIT && state_nxt == ST_COMMIT) ? sweep + 3'd1 : 3'd0;
    set_en_nxt    = (state_nxt != ST_RUN);
    cur_nxt       = '0;
    blink_nxt     = 1'b0;
    blink_cnt_nxt = '0;
    dig_nxt       = dig;

    case (state_nxt)
      ST_EDIT: begin
        if (!in_edit) begin
          cur_nxt   = CUR_SEC0;
          blink_nxt = 1'b1;
        end else begin
          if (act_left)       cur_nxt = {cursor[4:0], cursor[5]};
          else if (act_right) cur_nxt = {cursor[0], cursor[5:1]};
          else                cur_nxt = cursor;
          if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_nxt = ~blink;
          end else begin
            blink_nxt     = blink;
            blink_cnt_nxt = blink_cnt + 1'b1;
          end
        end
      end
      ST_COMMIT: cur_nxt = onehot6(sweep_nxt);
      default:   cur_nxt = '0;
    endcase

    case (state)
      ST_RUN: if (btn_mode) dig_nxt = live;
      ST_EDIT: begin
        if (go_commit) begin
          if (dig[5] == LIM_2 && dig[4] > HRS0_CLAMP) dig_nxt[4] = HRS0_CLAMP;
        end else begin
          dig_nxt = dig_step;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep     <= '0;
      set_en    <= 1'b0;
      cursor    <= '0;
      blink     <= 1'b0;
      blink_cnt <= '0;
      dig       <= '0;
    end else begin
      sweep     <= sweep_nxt;
      set_en    <= set_en_nxt;
      cursor    <= cur_nxt;
      blink     <= blink_nxt;
      blink_cnt <= blink_cnt_nxt;
      dig       <= dig_nxt;
    end
  end

  assign {n_hrs1, n_hrs0, n_min1, n_min0, n_sec1, n_sec0} = dig;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: snapshot, edit/wrap, clamp+sweep,
// simultaneous pulses, async reset mid-sweep and idle timeout behaviour.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_mode, btn_left, btn_right, btn_up, btn_down;
  logic [3:0] sec0, sec1, min0, min1, hrs0, hrs1;
  logic       set_en, blink;
  logic [5:0] cursor;
  logic [3:0] n_sec0, n_sec1, n_min0, n_min1, n_hrs0, n_hrs1;
  logic [23:0] nall;

  int n_cmp = 0;
  int n_err = 0;

  assign nall = {n_hrs1, n_hrs0, n_min1, n_min0, n_sec1, n_sec0};

  always #5 clk = ~clk;

  time_set_ctrl #(.TIMEOUT_CYCLES(8), .BLINK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_left(btn_left), .btn_right(btn_right),
    .btn_up(btn_up), .btn_down(btn_down),
    .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1), .hrs0(hrs0), .hrs1(hrs1),
    .set_en(set_en), .cursor(cursor),
    .n_sec0(n_sec0), .n_sec1(n_sec1), .n_min0(n_min0), .n_min1(n_min1),
    .n_hrs0(n_hrs0), .n_hrs1(n_hrs1), .blink(blink)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic l, input logic r, input logic u, input logic d);
    {btn_mode, btn_left, btn_right, btn_up, btn_down} = {m, l, r, u, d};
    step();
    {btn_mode, btn_left, btn_right, btn_up, btn_down} = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    {btn_mode, btn_left, btn_right, btn_up, btn_down} = '0;
    {hrs1, hrs0, min1, min0, sec1, sec0} = 24'h123456;
    step(); step();
    chk("rst_set_en", set_en, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_n_all",  nall,   0);
    chk("rst_blink",  blink,  0);
    @(negedge clk) rst_n = 1'b1;
    #1;

    // RUN ignores non-mode buttons
    pulse(0, 1, 0, 1, 0);
    chk("run_ign_set_en", set_en, 0);
    chk("run_ign_cursor", cursor, 0);

    // Enter and snapshot
    pulse(1, 0, 0, 0, 0);
    chk("enter_set_en", set_en, 1);
    chk("enter_cursor", cursor, 6'b000001);
    chk("enter_snap",   nall,   24'h123456);
    chk("enter_blink",  blink,  1);

    // Blink half-period of 4 cycles
    step(); step(); step();
    chk("blink_hold", blink, 1);
    step();
    chk("blink_toggle", blink, 0);

    // Cursor rotation and digit wrap
    pulse(0, 0, 1, 0, 0);
    chk("right_wrap", cursor, 6'b100000);
    pulse(0, 1, 0, 0, 0);
    chk("left_wrap", cursor, 6'b000001);
    pulse(0, 1, 0, 0, 0);
    chk("left_sec1", cursor, 6'b000010);
    pulse(0, 0, 0, 1, 0);
    chk("sec1_up_wrap", nall, 24'h123406);
    repeat (4) pulse(0, 1, 0, 0, 0);
    chk("cursor_hrs1", cursor, 6'b100000);
    pulse(0, 0, 0, 0, 1);
    chk("hrs1_down", nall, 24'h023406);
    pulse(0, 0, 0, 0, 1);
    chk("hrs1_down_wrap", nall, 24'h223406);

    // left + up: cursor only
    pulse(0, 1, 0, 1, 0);
    chk("left_up_cursor", cursor, 6'b000001);
    chk("left_up_digits", nall, 24'h223406);

    // hrs0 to 9 with hrs1=2 (limit stays 9 while editing)
    pulse(0, 0, 1, 0, 0);
    pulse(0, 0, 1, 0, 0);
    chk("cursor_hrs0", cursor, 6'b010000);
    repeat (3) pulse(0, 0, 0, 0, 1);
    chk("hrs0_to_9", nall, 24'h293406);

    // mode + up: clamp to 23, no increment, sweep six digits
    pulse(1, 0, 0, 1, 0);
    chk("commit_set_en", set_en, 1);
    chk("commit_clamp", nall, 24'h233406);
    chk("commit_blink", blink, 0);
    chk("sweep0", cursor, 6'b000001);
    for (int i = 1; i < 6; i++) begin
      step();
      chk("sweep_cursor", cursor, 32'(1) << i);
      chk("sweep_stable", nall, 24'h233406);
    end
    step();
    chk("run_set_en", set_en, 0);
    chk("run_cursor", cursor, 0);
    chk("run_hours_23", {n_hrs1, n_hrs0}, 8'h23);

    // Async reset at sweep index 3
    pulse(1, 0, 0, 0, 0);
    chk("reenter_snap", nall, 24'h123456);
    pulse(1, 0, 0, 0, 0);
    step(); step(); step();
    chk("sweep3", cursor, 6'b001000);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_set_en", set_en, 0);
    chk("arst_cursor", cursor, 0);
    chk("arst_n_all",  nall,   0);
    chk("arst_blink",  blink,  0);
    rst_n = 1'b1;
    pulse(0, 1, 0, 1, 0);
    chk("post_rst_set_en", set_en, 0);
    chk("post_rst_cursor", cursor, 0);
    chk("post_rst_n_all",  nall,   0);
    pulse(1, 0, 0, 0, 0);
    chk("post_rst_enter", cursor, 6'b000001);
    chk("post_rst_snap",  nall,   24'h123456);

`ifdef TIME_SET_TIMEOUT_EN
    // Eight idle cycles after the last pulse auto-commit
    pulse(0, 1, 0, 0, 0);
    repeat (7) step();
    chk("to_not_yet", cursor, 6'b000010);
    step();
    chk("to_commit_cursor", cursor, 6'b000001);
    chk("to_commit_blink",  blink,  0);
    repeat (6) step();
    chk("to_run", set_en, 0);
    // A pulse on cycle 6 restarts the count
    pulse(1, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    repeat (5) step();
    pulse(0, 0, 0, 1, 0);
    repeat (7) step();
    chk("to_restart_hold", cursor, 6'b000010);
    chk("to_restart_edit", set_en, 1);
    step();
    chk("to_restart_commit", cursor, 6'b000001);
`else
    pulse(0, 1, 0, 0, 0);
    repeat (10000) step();
    chk("no_to_set_en", set_en, 1);
    chk("no_to_cursor", cursor, 6'b000010);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Time-set controller for the digital clock datapath. It turns debounced user button pulses into the freeze, cursor and new-digit signals of the clock counter. It snapshots the running time, lets the user edit one BCD digit at a time with range-limited wrap, and commits all six digits with an hours-range fix-up before returning the counter to free-running.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1000, idle cycles in EDIT before auto-commit (only with the macro); at least 2.
- BLINK_DIV, 500, cycles per half-period of the cursor blink; at least 1.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_mode, btn_left, btn_right, btn_up, btn_down  in  1 each  single-cycle debounced pulses.
- sec0, sec1, min0, min1, hrs0, hrs1  in  4 each  live BCD digits from the counter.
- set_en  out  1  freezes the counter and enables its digit load.
- cursor  out  6  one-hot digit select: bit0 = sec0 … bit5 = hrs1; 0 in RUN.
- n_sec0, n_sec1, n_min0, n_min1, n_hrs0, n_hrs1  out  4 each  edit values.
- blink  out  1  cursor blink phase for the display.

## Operation
- States are RUN, EDIT and COMMIT, with a 3-bit sweep index used in COMMIT.
- **RUN**
  - Outputs: set_en=0, cursor=0.
  - A btn_mode pulse loads the six edit registers from the live digits, sets cursor=000001 and moves to EDIT.
  - All other buttons are ignored.
- **EDIT**
  - Outputs: set_en=1. The counter holds, and it rewrites the selected digit from the n_* output every cycle, so edits appear live.
  - Button priority is mode > left > right > up > down. Exactly one action is taken per cycle, and lower-priority pulses in the same cycle are dropped.
  - left: rotate cursor toward higher significance (100000 wraps to 000001).
  - right: rotate cursor toward lower significance (000001 wraps to 100000).
  - up/down: increment/decrement the selected edit digit, wrapping within its limit.
    - Limits are sec0 0–9, sec1 0–5, min0 0–9, min1 0–5, hrs0 0–9, hrs1 0–2.
    - The hrs0 limit stays 0–9 while editing, regardless of hrs1.
  - mode: clamp hours (if hrs1==2 and hrs0>3, set hrs0 to 3), then go to COMMIT with sweep index 0.
- **COMMIT**
  - Outputs: set_en=1, cursor = one-hot of the sweep index, from 000001 to 100000 over 6 cycles. Every digit is rewritten with its clamped value.
  - After index 5, go to RUN.
  - All buttons are ignored.
- **blink**
  - In EDIT, blink toggles every BLINK_DIV cycles. It starts at 1 on entry to EDIT.
  - It is 0 in RUN and COMMIT.
- **Reset** (asynchronous, any state including mid-COMMIT): state=RUN, set_en=0, cursor=0, all n_* = 0, blink=0, sweep and timeout counters = 0.

## Timing
- All outputs are registered.
- A btn_mode pulse in RUN at edge t gives set_en=1 and cursor=000001 after edge t, with n_* holding the snapshot from that edge.
- An up/down pulse at edge t changes n_* after edge t. The counter digit updates one edge later.
- A btn_mode pulse in EDIT at edge t gives COMMIT cursors 000001…100000 after edges t … t+5. After edge t+6, set_en=0 and cursor=0.
- n_* is stable throughout COMMIT.

## Configuration
- **TIME_SET_TIMEOUT_EN defined:**
  - An idle counter runs in EDIT. It clears on entry and on any button pulse.
  - When it reaches TIMEOUT_CYCLES-1 with no pulse, the controller behaves exactly as if btn_mode had been pressed: clamp, then COMMIT.
  - A pulse in the expiry cycle takes priority over the timeout.
- **TIME_SET_TIMEOUT_EN undefined:** there is no counter, and EDIT persists until btn_mode.

## Structure
- Package time_set_pkg holds:
  - the state enum;
  - the cursor one-hot constants CUR_SEC0 … CUR_HRS1;
  - the digit limit constants (9, 5, 2, and 3 for the hours clamp).
- Sub-module bcd_digit_step is combinational: inputs are a 4-bit value, a 4-bit limit, up and down; the output is the wrapped next value.
- All state, sweep, blink and timeout logic lives in time_set_ctrl.

## Test plan
- **Enter and snapshot:** live time 12:34:56, pulse mode. Next cycle: set_en=1, cursor=000001, n_* = 6,5,4,3,2,1, blink=1.
- **Wrap and cursor rotation:**
  - From sec1=5, pulse up: n_sec1=0.
  - At cursor=000001, pulse right: cursor=100000.
  - From hrs1=0, pulse down: n_hrs1=2.
- **Clamp on commit:** hrs1=2 and hrs0=9 in EDIT, pulse mode. n_hrs0=3. The cursor sweeps 000001…100000 over 6 cycles, then set_en=0 and cursor=0, and the counter reads 23:xx:xx.
- **Simultaneous pulses:** mode and up in the same EDIT cycle gives COMMIT with no increment. left and up together moves the cursor only.
- **Async reset mid-COMMIT:** drop rst_n at sweep index 3. All outputs go to 0 immediately. After release, the state is RUN and ignores up/left.
- **Timeout (with TIME_SET_TIMEOUT_EN, TIMEOUT_CYCLES=8):**
  - 8 idle cycles in EDIT: auto-commit.
  - A btn_up pulse on cycle 6 restarts the count.
  - Without the macro: still in EDIT after 10000 cycles.
